// File: rtl/async_fifo_rd_packer.sv
// Read-side byte packer for the 8-bit async FIFO: pops FWFT bytes and emits little-endian words on valid/ready.
// Optional idle flush of partial words is enabled with `define ASYNC_FIFO_RD_FLUSH_EN.
module async_fifo_rd_packer #(
  parameter int WORD_BYTES   = 4,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                    rclk,
  input  logic                    rrst_n,
  input  logic [7:0]              rdata,
  input  logic                    rempty,
  output logic                    rinc,
  output logic [8*WORD_BYTES-1:0] m_data,
  output logic [WORD_BYTES-1:0]   m_keep,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [15:0]             word_cnt
);
  localparam int            CW   = $clog2(WORD_BYTES);
  localparam logic [CW-1:0] LAST = CW'(WORD_BYTES-1);

  logic [CW-1:0]               cnt;
  logic [WORD_BYTES-2:0][7:0]  acc;
  logic                        slot_free, last_pop, flush, load, xfer;
  logic [8*WORD_BYTES-1:0]     load_data;
  logic [WORD_BYTES-1:0]       load_keep;

  assign slot_free = !m_valid || m_ready;
  // Only the word-completing pop needs the output slot; earlier bytes park in acc.
  assign rinc      = rrst_n && !rempty && ((cnt != LAST) || slot_free);
  assign last_pop  = rinc && (cnt == LAST);
  assign xfer      = m_valid && m_ready;
  assign load      = last_pop || flush;

`ifdef ASYNC_FIFO_RD_FLUSH_EN
  localparam int IW = $clog2(FLUSH_CYCLES+1);
  logic [IW-1:0] idle;

  // Flush only fires on an empty FIFO, so it can never coincide with a pop.
  assign flush = (idle >= IW'(FLUSH_CYCLES)) && (cnt != '0) && rempty && slot_free;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)                              idle <= '0;
    else if (!rempty || cnt == '0 || flush)   idle <= '0;
    else if (idle != IW'(FLUSH_CYCLES))       idle <= idle + IW'(1);
  end
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    load_data = '0;
    load_keep = '1;
    for (int i = 0; i < WORD_BYTES-1; i++) load_data[8*i +: 8] = acc[i];
    if (flush) begin
      // Stale bytes from an earlier word may sit above cnt; zero them.
      for (int i = 0; i < WORD_BYTES-1; i++)
        if (CW'(i) >= cnt) load_data[8*i +: 8] = 8'h00;
      load_keep = (WORD_BYTES'(1) << cnt) - WORD_BYTES'(1);
    end else begin
      load_data[8*(WORD_BYTES-1) +: 8] = rdata;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_keep   <= '0;
      word_cnt <= '0;
      cnt      <= '0;
      acc      <= '0;
    end else begin
      if (xfer) word_cnt <= word_cnt + 16'd1;
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= load_data;
        m_keep  <= load_keep;
      end else if (xfer) begin
        m_valid <= 1'b0;
      end
      if (load) begin
        cnt <= '0;
      end else if (rinc) begin
        acc[cnt] <= rdata;
        cnt      <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_async_fifo_rd_packer.sv
// Bench for async_fifo_rd_packer: FIFO/queue model, cycle table for backpressure, random stream vs scoreboard.
module tb_async_fifo_rd_packer;
  localparam int WB = 4;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic [7:0]    rdata = 8'h00;
  logic          rempty = 1'b1;
  logic          rinc;
  logic [31:0]   m_data;
  logic [3:0]    m_keep;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [15:0]   word_cnt;

  always #5 rclk = ~rclk;

  async_fifo_rd_packer #(.WORD_BYTES(WB), .FLUSH_CYCLES(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_ready(m_ready), .word_cnt(word_cnt)
  );

  typedef struct {
    logic        rdy;
    logic        rinc;
    logic        vld;
    logic [31:0] data;
  } vec_t;

  int            ncmp = 0, nfail = 0;
  byte unsigned  fq[$];
  byte unsigned  acc_q[$];
  logic [31:0]   out_q[$];
  logic [15:0]   wc = 16'd0;
  logic [31:0]   last_word = 32'h0;
  bit            mdl = 1'b0, bubble = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    rempty = (fq.size() == 0) || bubble;
    rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  // Sample point of one cycle: check against the scoreboard, then account for what the edge will do.
  task automatic step();
    bit           exp_v;
    byte unsigned b;
    logic [31:0]  w;
    if (mdl && rrst_n) begin
      exp_v = out_q.size() != 0;
      chk("rinc_rule", rinc, !rempty && (acc_q.size() < WB-1 || !exp_v || m_ready));
      chk("m_valid", m_valid, exp_v);
      if (exp_v) begin
        chk("m_data", m_data, out_q[0]);
        chk("m_keep", m_keep, 4'hF);
      end
      chk("word_cnt", word_cnt, wc);
      if (exp_v && m_ready) begin
        void'(out_q.pop_front());
        wc++;
      end
    end
    if (rempty) chk("rinc_while_empty", rinc, 1'b0);
    if (m_valid && m_ready) last_word = m_data;
    if (rinc && !rempty) begin
      b = fq.pop_front();
      if (mdl) begin
        acc_q.push_back(b);
        if (acc_q.size() == WB) begin
          w = '0;
          for (int i = 0; i < WB; i++) w[8*i +: 8] = acc_q[i];
          out_q.push_back(w);
          acc_q.delete();
        end
      end
    end
  endtask

  task automatic cyc();
    drive();
    #1;
    step();
    @(negedge rclk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic rst();
    rrst_n = 1'b0;
    @(negedge rclk);
    @(negedge rclk);
    acc_q.delete();
    out_q.delete();
    wc = 16'd0;
    rrst_n = 1'b1;
  endtask

  task automatic push(input byte unsigned b);
    fq.push_back(b);
  endtask

  vec_t t3[16];
  int   ce, n, first, nv;
  logic [31:0] cap_d;
  logic [3:0]  cap_k;

  initial begin
    // rdy, expected rinc, expected m_valid, expected m_data (only when valid)
    t3[0]  = '{1'b0, 1'b1, 1'b0, 32'h0};
    t3[1]  = '{1'b0, 1'b1, 1'b0, 32'h0};
    t3[2]  = '{1'b0, 1'b1, 1'b0, 32'h0};
    t3[3]  = '{1'b0, 1'b1, 1'b0, 32'h0};
    t3[4]  = '{1'b0, 1'b1, 1'b1, 32'h44332211};
    t3[5]  = '{1'b0, 1'b1, 1'b1, 32'h44332211};
    t3[6]  = '{1'b0, 1'b1, 1'b1, 32'h44332211};
    t3[7]  = '{1'b0, 1'b0, 1'b1, 32'h44332211};
    t3[8]  = '{1'b0, 1'b0, 1'b1, 32'h44332211};
    t3[9]  = '{1'b1, 1'b1, 1'b1, 32'h44332211};
    t3[10] = '{1'b1, 1'b1, 1'b1, 32'h88776655};
    t3[11] = '{1'b1, 1'b1, 1'b0, 32'h0};
    t3[12] = '{1'b1, 1'b1, 1'b0, 32'h0};
    t3[13] = '{1'b1, 1'b1, 1'b0, 32'h0};
    t3[14] = '{1'b1, 1'b0, 1'b1, 32'hCCBBAA99};
    t3[15] = '{1'b1, 1'b0, 1'b0, 32'h0};

    @(negedge rclk);
    rst();

    // T1: reset while two bytes of a word are held
    mdl = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 6; i++) push(8'(i));
    run(7);
    chk("t1_pre_word_cnt", word_cnt, 16'd1);
    for (int i = 1; i <= 4; i++) push(8'(8'hA0 + i));
    rrst_n = 1'b0;
    drive();
    #1;
    chk("t1_rst_m_valid", m_valid, 1'b0);
    chk("t1_rst_word_cnt", word_cnt, 16'd0);
    chk("t1_rst_rinc", rinc, 1'b0);
    chk("t1_rst_m_data", m_data, 32'h0);
    chk("t1_rst_m_keep", m_keep, 4'h0);
    @(negedge rclk);
    @(negedge rclk);
    acc_q.delete(); out_q.delete(); wc = 16'd0;
    rrst_n = 1'b1;
    run(6);
    chk("t1_fresh_word", last_word, 32'hA4A3A2A1);
    chk("t1_word_cnt", word_cnt, 16'd1);

    // T2: back-to-back stream
    rst();
    for (int i = 1; i <= 8; i++) push(8'(8'h11 * i));
    for (int i = 0; i < 8; i++) begin
      drive();
      #1;
      chk("t2_rinc_run", rinc, 1'b1);
      step();
      @(negedge rclk);
    end
    run(3);
    chk("t2_word_cnt", word_cnt, 16'd2);
    chk("t2_last_word", last_word, 32'h88776655);

    // T3: backpressure, cycle-by-cycle table
    rst();
    for (int i = 1; i <= 12; i++) push(8'(8'h11 * i));
    for (int i = 0; i < 16; i++) begin
      m_ready = t3[i].rdy;
      drive();
      #1;
      chk($sformatf("t3_rinc[%0d]", i), rinc, t3[i].rinc);
      chk($sformatf("t3_valid[%0d]", i), m_valid, t3[i].vld);
      if (t3[i].vld) chk($sformatf("t3_data[%0d]", i), m_data, t3[i].data);
      step();
      @(negedge rclk);
    end
    chk("t3_word_cnt", word_cnt, 16'd3);
    chk("t3_fifo_left", fq.size(), 0);

    // T4: empty flag toggling every other cycle
    rst();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
    for (int i = 0; i < 20; i++) begin
      bubble = i[0];
      cyc();
    end
    bubble = 1'b0;
    chk("t4_word_cnt", word_cnt, 16'd2);
    chk("t4_last_word", last_word, 32'hA7A6A5A4);

    // Random traffic against the scoreboard; empty runs kept short so no flush can trigger
    rst();
    ce = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 55) push(8'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      bubble  = ($urandom_range(0, 4) == 0);
      if (ce >= 6) begin
        if (fq.size() == 0) push(8'($urandom));
        bubble = 1'b0;
      end
      cyc();
      ce = rempty ? ce + 1 : 0;
    end
    n = (WB - (acc_q.size() + fq.size()) % WB) % WB;
    for (int i = 0; i < n; i++) push(8'($urandom));
    bubble = 1'b0; m_ready = 1'b1;
    n = fq.size() + 20;
    run(n);
    chk("rand_fifo_drained", fq.size(), 0);
    chk("rand_partial_left", acc_q.size(), 0);
    chk("rand_valid_idle", m_valid, 1'b0);
    chk("rand_word_cnt", word_cnt, wc);

    mdl = 1'b0;
`ifdef ASYNC_FIFO_RD_FLUSH_EN
    // T5: partial word flushed after 16 idle cycles
    rst();
    m_ready = 1'b1;
    push(8'hAA); push(8'hBB);
    first = -1; cap_d = '0; cap_k = '0;
    for (int c = 0; c < 40; c++) begin
      drive();
      #1;
      if (m_valid && first < 0) begin first = c; cap_d = m_data; cap_k = m_keep; end
      step();
      @(negedge rclk);
    end
    chk("t5_flush_cycle", first, 19);
    chk("t5_flush_data", cap_d, 32'h0000BBAA);
    chk("t5_flush_keep", cap_k, 4'h3);

    // T6: byte arrives on the firing cycle, so it is packed instead of flushing
    rst();
    push(8'hAA); push(8'hBB);
    first = -1; cap_d = '0; cap_k = '0;
    for (int c = 0; c < 60; c++) begin
      if (c == 18) push(8'hCC);
      drive();
      #1;
      if (c == 18) chk("t6_race_rinc", rinc, 1'b1);
      if (c == 19) chk("t6_no_flush", m_valid, 1'b0);
      if (m_valid && first < 0) begin first = c; cap_d = m_data; cap_k = m_keep; end
      step();
      @(negedge rclk);
    end
    chk("t6_flush_cycle", first, 36);
    chk("t6_flush_data", cap_d, 32'h00CCBBAA);
    chk("t6_flush_keep", cap_k, 4'h7);
`else
    // Without flush, a partial word waits indefinitely
    rst();
    push(8'hAA); push(8'hBB);
    nv = 0;
    for (int c = 0; c < 102; c++) begin
      drive();
      #1;
      if (m_valid) nv++;
      step();
      @(negedge rclk);
    end
    chk("noflush_valid_count", nv, 0);
    chk("noflush_word_cnt", word_cnt, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
